// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   ld_rewrite_e : decoded load code (byte/half/word, signed/unsigned, none)
//   st_rewrite_e : decoded store code (byte/half/word, none)
//   lsu_state_e  : transaction FSM states
//   BMASK_*      : base byte-enable patterns, shifted by the byte offset
package lsu_pkg;

  typedef enum logic [2:0] {
    LB      = 3'd0,
    LH      = 3'd1,
    LW      = 3'd2,
    LBU     = 3'd3,
    LHU     = 3'd4,
    LD_NONE = 3'd5
  } ld_rewrite_e;

  typedef enum logic [1:0] {
    SB      = 2'd0,
    SH      = 2'd1,
    SW      = 2'd2,
    ST_NONE = 2'd3
  } st_rewrite_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BMASK_B = 4'b0001;
  localparam logic [3:0] BMASK_H = 4'b0011;
  localparam logic [3:0] BMASK_W = 4'b1111;

endpackage

// File: rtl/lsu_ld_align.sv
// Load data formatter: picks the addressed byte/half out of a read word and
// sign- or zero-extends it. Purely combinational so it can sit on any read path.
//   rdata_i : raw 32-bit read word
//   off_i   : byte offset of the access within the word
//   code_i  : load code
//   data_o  : formatted 32-bit load result
module lsu_ld_align
  import lsu_pkg::*;
(
  input  logic [31:0]  rdata_i,
  input  logic [1:0]   off_i,
  input  ld_rewrite_e  code_i,
  output logic [31:0]  data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[7:0];
    case (off_i)
      2'd0:    byte_v = rdata_i[7:0];
      2'd1:    byte_v = rdata_i[15:8];
      2'd2:    byte_v = rdata_i[23:16];
      default: byte_v = rdata_i[31:24];
    endcase
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = rdata_i;
    case (code_i)
      LB:      data_o = {{24{byte_v[7]}}, byte_v};
      LH:      data_o = {{16{half_v[15]}}, half_v};
      LBU:     data_o = {24'd0, byte_v};
      LHU:     data_o = {16'd0, half_v};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: accepts one core request at a time, checks alignment,
// drives a handshaked memory transaction, and returns formatted load data.
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_req_vld/o_ready              : core request handshake
//   i_addr, i_st_data              : effective byte address, store data
//   i_ld_rewrite, i_st_rewrite     : decoded load/store codes
//   i_mem_wren, i_rden             : store / load request (store wins if both)
//   o_ld_vld, o_ld_data            : load completion pulse and held result
//   o_st_done                      : store completion pulse
//   o_misalign, o_timeout          : reject / abort pulses
//   o_mem_*, i_mem_ack, i_mem_rdata: memory port
//
// state | meaning
// IDLE  | ready; decode and accept or reject a request
// REQ   | memory request outstanding, waiting for ack or timeout
// RESP  | one-cycle completion pulse (load data valid or store done)
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_vld,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_st_data,
  input  logic [2:0]        i_ld_rewrite,
  input  logic [1:0]        i_st_rewrite,
  input  logic              i_mem_wren,
  input  logic              i_rden,
  output logic              o_ready,
  output logic              o_ld_vld,
  output logic [31:0]       o_ld_data,
  output logic              o_st_done,
  output logic              o_misalign,
  output logic              o_timeout,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [3:0]        o_mem_bmask,
  output logic [31:0]       o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_rdata
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic              we_q, we_d;
  logic [3:0]        bmask_q, bmask_d;
  logic [31:0]       wdata_q, wdata_d;
  ld_rewrite_e       ld_code_q, ld_code_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              misalign_q, misalign_d;
  logic              timeout_q, timeout_d;

  logic              st_ok, ld_ok, good;
  logic [31:0]       ld_fmt;
  logic [3:0]        st_bmask;
  logic [31:0]       st_wdata;

  lsu_ld_align u_ld_align (
    .rdata_i (i_mem_rdata),
    .off_i   (off_q),
    .code_i  (ld_code_q),
    .data_o  (ld_fmt)
  );

  // Request decode: legality and store lane placement.
  always_comb begin
    st_ok    = 1'b0;
    st_bmask = BMASK_W;
    st_wdata = i_st_data;
    case (st_rewrite_e'(i_st_rewrite))
      SB: begin
        st_ok    = 1'b1;
        st_bmask = BMASK_B << i_addr[1:0];
        st_wdata = {4{i_st_data[7:0]}};
      end
      SH: begin
        st_ok    = ~i_addr[0];
        st_bmask = BMASK_H << i_addr[1:0];
        st_wdata = {2{i_st_data[15:0]}};
      end
      SW:      st_ok = (i_addr[1:0] == 2'b00);
      default: st_ok = 1'b0;
    endcase

    ld_ok = 1'b0;
    case (ld_rewrite_e'(i_ld_rewrite))
      LB, LBU: ld_ok = 1'b1;
      LH, LHU: ld_ok = ~i_addr[0];
      LW:      ld_ok = (i_addr[1:0] == 2'b00);
      default: ld_ok = 1'b0;
    endcase

    good = i_mem_wren ? st_ok : ld_ok;
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    off_d      = off_q;
    we_d       = we_q;
    bmask_d    = bmask_q;
    wdata_d    = wdata_q;
    ld_code_d  = ld_code_q;
    ld_data_d  = ld_data_q;
    misalign_d = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_req_vld && (i_mem_wren || i_rden)) begin
          if (good) begin
            state_d   = REQ;
            timer_d   = TW'(TIMEOUT - 1);
            addr_d    = {i_addr[ADDR_W-1:2], 2'b00};
            off_d     = i_addr[1:0];
            we_d      = i_mem_wren;
            bmask_d   = i_mem_wren ? st_bmask : BMASK_W;
            wdata_d   = i_mem_wren ? st_wdata : 32'd0;
            ld_code_d = i_mem_wren ? LD_NONE : ld_rewrite_e'(i_ld_rewrite);
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REQ: begin
        // Ack takes priority over the terminal count in the last allowed cycle.
        if (i_mem_ack) begin
          state_d = RESP;
          if (!we_q) ld_data_d = ld_fmt;
        end else if (timer_q == '0) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      addr_q     <= '0;
      off_q      <= 2'd0;
      we_q       <= 1'b0;
      bmask_q    <= 4'd0;
      wdata_q    <= 32'd0;
      ld_code_q  <= LB;
      ld_data_q  <= 32'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      we_q       <= we_d;
      bmask_q    <= bmask_d;
      wdata_q    <= wdata_d;
      ld_code_q  <= ld_code_d;
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_ready     = (state_q == IDLE);
  assign o_mem_req   = (state_q == REQ);
  assign o_ld_vld    = (state_q == RESP) && !we_q;
  assign o_st_done   = (state_q == RESP) && we_q;
  assign o_ld_data   = ld_data_q;
  assign o_misalign  = misalign_q;
  assign o_timeout   = timeout_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_bmask = bmask_q;
  assign o_mem_wdata = wdata_q;

endmodule
